// File: rtl/rrv64_l2_l1d_axi_rsp_if.sv
// -----------------------------------------------------------------------------
// rrv64_l2_l1d_axi_rsp_if
// AXI channel bundle between the L1D (master) and the L2-side responder
// (slave). Fixed 4-beat line bursts only, so there are no len/size/burst
// fields.
//   AR : ar_valid, ar_ready, ar_id, ar_addr
//   R  : r_valid, r_ready, r_id, r_data, r_last, r_resp
//   AW : aw_valid, aw_ready, aw_id, aw_addr
//   W  : w_valid, w_ready, w_data, w_last
//   B  : b_valid, b_ready, b_id, b_resp
// -----------------------------------------------------------------------------
interface rrv64_l2_l1d_axi_rsp_if #(
  parameter int ID_W   = 3,
  parameter int ADDR_W = 56,
  parameter int DATA_W = 128
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;

  logic              r_valid;
  logic              r_ready;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [1:0]        r_resp;

  logic              aw_valid;
  logic              aw_ready;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;

  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              w_last;

  logic              b_valid;
  logic              b_ready;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;

  modport master (
    output ar_valid, ar_id, ar_addr, input ar_ready,
    input  r_valid, r_id, r_data, r_last, r_resp, output r_ready,
    output aw_valid, aw_id, aw_addr, input aw_ready,
    output w_valid, w_data, w_last, input w_ready,
    input  b_valid, b_id, b_resp, output b_ready
  );

  modport slave (
    input  ar_valid, ar_id, ar_addr, output ar_ready,
    output r_valid, r_id, r_data, r_last, r_resp, input r_ready,
    input  aw_valid, aw_id, aw_addr, output aw_ready,
    input  w_valid, w_data, w_last, output w_ready,
    output b_valid, b_id, b_resp, input b_ready
  );
endinterface

// File: rtl/rrv64_l2_l1d_axi_rsp.sv
// -----------------------------------------------------------------------------
// rrv64_l2_l1d_axi_rsp
// L2-side AXI responder for the L1D channel. Turns 4-beat 128-bit line
// refills (AR/R) and writebacks (AW/W/B) into single 512-bit line requests
// to the L2 core. One line in flight at a time.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   axi (slave)       : AR/R/AW/W/B channels from the L1D
//   l2_req_valid_o    : line request valid (held until l2_req_ready_i)
//   l2_req_ready_i    : L2 accepts the request
//   l2_req_wr_o       : 1 = line write, 0 = line read
//   l2_req_addr_o     : line address (addr[55:6])
//   l2_req_data_o     : assembled write line
//   l2_rsp_valid_i    : read line return pulse (no backpressure)
//   l2_rsp_data_i     : returned line
// -----------------------------------------------------------------------------
module rrv64_l2_l1d_axi_rsp #(
  parameter int ID_W        = 3,
  parameter int ADDR_W      = 56,
  parameter int DATA_W      = 128,
  parameter int LINE_W      = 512,
  parameter int BURST_N     = 4,
  parameter int LINE_ADDR_W = ADDR_W - 6
) (
  input  logic                   clk,
  input  logic                   rst,
  rrv64_l2_l1d_axi_rsp_if.slave  axi,
  output logic                   l2_req_valid_o,
  input  logic                   l2_req_ready_i,
  output logic                   l2_req_wr_o,
  output logic [LINE_ADDR_W-1:0] l2_req_addr_o,
  output logic [LINE_W-1:0]      l2_req_data_o,
  input  logic                   l2_rsp_valid_i,
  input  logic [LINE_W-1:0]      l2_rsp_data_i
);

  localparam int CNT_W = $clog2(BURST_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_BEAT = 3'd3,
    S_WR_DATA = 3'd4,
    S_WR_REQ  = 3'd5,
    S_WR_RESP = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LINE_W-1:0]      buf_q, buf_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic                   err_q, err_d;
  logic                   prio_rd_q, prio_rd_d;

  logic                   grant_rd_s;
  logic                   ar_ready_s;
  logic                   aw_ready_s;
  logic                   in_idle_s;
  logic                   unused_addr_lo_s;

  // Byte offset inside the line is ignored: bursts always start at beat 0.
  assign unused_addr_lo_s = ^{axi.ar_addr[5:0], axi.aw_addr[5:0]};

  // Arbitration: a lone valid wins; with both or neither, the round-robin bit
  // picks. Exactly one ready is high in IDLE and none during reset.
  assign grant_rd_s = axi.ar_valid ? (!axi.aw_valid || prio_rd_q)
                                   : (!axi.aw_valid && prio_rd_q);
  assign in_idle_s  = (state_q == S_IDLE) && !rst;
  assign ar_ready_s = in_idle_s && grant_rd_s;
  assign aw_ready_s = in_idle_s && !grant_rd_s;

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    id_d      = id_q;
    addr_d    = addr_q;
    err_d     = err_q;
    prio_rd_d = prio_rd_q;
    case (state_q)
      S_IDLE: begin
        if (axi.ar_valid && ar_ready_s) begin
          id_d      = axi.ar_id;
          addr_d    = axi.ar_addr[ADDR_W-1:6];
          cnt_d     = '0;
          prio_rd_d = ~prio_rd_q;
          state_d   = S_RD_REQ;
        end else if (axi.aw_valid && aw_ready_s) begin
          id_d      = axi.aw_id;
          addr_d    = axi.aw_addr[ADDR_W-1:6];
          cnt_d     = '0;
          err_d     = 1'b0;
          prio_rd_d = ~prio_rd_q;
          state_d   = S_WR_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (l2_req_ready_i) begin
          state_d = S_RD_WAIT;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (l2_rsp_valid_i) begin
          buf_d   = l2_rsp_data_i;
          cnt_d   = '0;
          state_d = S_RD_BEAT;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_BEAT: begin
        if (axi.r_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CNT_LAST) ? S_IDLE : S_RD_BEAT;
        end else begin
          state_d = S_RD_BEAT;
        end
      end
      S_WR_DATA: begin
        if (axi.w_valid) begin
          buf_d[cnt_q*DATA_W +: DATA_W] = axi.w_data;
          cnt_d = cnt_q + 1'b1;
          // A burst that is short or long is answered SLVERR and never
          // reaches the L2.
          if (axi.w_last && (cnt_q != CNT_LAST)) begin
            err_d   = 1'b1;
            state_d = S_WR_RESP;
          end else if (cnt_q == CNT_LAST) begin
            err_d   = !axi.w_last;
            state_d = axi.w_last ? S_WR_REQ : S_WR_RESP;
          end else begin
            state_d = S_WR_DATA;
          end
        end else begin
          state_d = S_WR_DATA;
        end
      end
      S_WR_REQ: begin
        if (l2_req_ready_i) begin
          state_d = S_WR_RESP;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_RESP: begin
        if (axi.b_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WR_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset discards any buffered line.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      buf_q     <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      prio_rd_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      prio_rd_q <= prio_rd_d;
    end
  end

  // Outputs decode straight from flops, so r_data/r_last stay stable under
  // backpressure and l2_req_* stay stable until accepted.
  assign axi.ar_ready  = ar_ready_s;
  assign axi.aw_ready  = aw_ready_s;
  assign axi.r_valid   = (state_q == S_RD_BEAT);
  assign axi.r_data    = (state_q == S_RD_BEAT) ? buf_q[cnt_q*DATA_W +: DATA_W] : '0;
  assign axi.r_last    = (state_q == S_RD_BEAT) && (cnt_q == CNT_LAST);
  assign axi.r_id      = id_q;
  assign axi.r_resp    = 2'b00;
  assign axi.w_ready   = (state_q == S_WR_DATA);
  assign axi.b_valid   = (state_q == S_WR_RESP);
  assign axi.b_id      = id_q;
  assign axi.b_resp    = ((state_q == S_WR_RESP) && err_q) ? 2'b10 : 2'b00;
  assign l2_req_valid_o = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign l2_req_wr_o    = (state_q == S_WR_REQ);
  assign l2_req_addr_o  = addr_q;
  assign l2_req_data_o  = buf_q;

endmodule

// File: tb/tb_rrv64_l2_l1d_axi_rsp.sv
module tb_rrv64_l2_l1d_axi_rsp;

  logic         clk = 1'b0;
  logic         rst;
  logic         l2_req_valid;
  logic         l2_req_ready;
  logic         l2_req_wr;
  logic [49:0]  l2_req_addr;
  logic [511:0] l2_req_data;
  logic         l2_rsp_valid;
  logic [511:0] l2_rsp_data;
  logic         hold;

  int n_checks = 0;
  int n_fail   = 0;

  rrv64_l2_l1d_axi_rsp_if #(.ID_W(3), .ADDR_W(56), .DATA_W(128)) axi ();

  rrv64_l2_l1d_axi_rsp dut (
    .clk            (clk),
    .rst            (rst),
    .axi            (axi),
    .l2_req_valid_o (l2_req_valid),
    .l2_req_ready_i (l2_req_ready),
    .l2_req_wr_o    (l2_req_wr),
    .l2_req_addr_o  (l2_req_addr),
    .l2_req_data_o  (l2_req_data),
    .l2_rsp_valid_i (l2_rsp_valid),
    .l2_rsp_data_i  (l2_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_busy_readies();
    check_val("busy_ar_ready", axi.ar_ready, 1'b0);
    check_val("busy_aw_ready", axi.aw_ready, 1'b0);
  endtask

  // Full read: accept, L2 request, line return, beats with optional stall or
  // a reset pulse when beat number abort_beat is presented.
  task automatic do_read(input logic [2:0] id, input logic [55:0] addr, input logic [511:0] line,
                         input int stall_beat, input int abort_beat);
    int hs;
    int stall_left;
    int cyc;
    axi.ar_valid = 1'b1; axi.ar_id = id; axi.ar_addr = addr;
    #1;
    check_val("rd_ar_ready", axi.ar_ready, 1'b1);
    check_val("rd_aw_ready_off", axi.aw_ready, 1'b0);
    tick();
    if (!hold) axi.ar_valid = 1'b0;
    #1;
    check_val("rd_req_valid", l2_req_valid, 1'b1);
    check_val("rd_req_wr", l2_req_wr, 1'b0);
    check_val("rd_req_addr", l2_req_addr, addr[55:6]);
    check_busy_readies();
    tick();
    l2_rsp_valid = 1'b1; l2_rsp_data = line;
    #1;
    check_val("rd_wait_req_low", l2_req_valid, 1'b0);
    check_val("rd_wait_r_valid", axi.r_valid, 1'b0);
    tick();
    l2_rsp_valid = 1'b0; l2_rsp_data = '0;
    hs = 0; stall_left = 3; cyc = 0;
    while (hs < 4 && cyc < 20) begin
      if (hs == abort_beat) begin
        rst = 1'b1;
        tick();
        check_val("abort_r_valid", axi.r_valid, 1'b0);
        check_val("abort_req_valid", l2_req_valid, 1'b0);
        check_val("abort_ar_ready", axi.ar_ready, 1'b0);
        rst = 1'b0;
        return;
      end
      axi.r_ready = (hs == stall_beat && stall_left > 0) ? 1'b0 : 1'b1;
      #1;
      check_val("r_valid", axi.r_valid, 1'b1);
      check_val("r_data", axi.r_data, line[hs*128 +: 128]);
      check_val("r_last", axi.r_last, (hs == 3) ? 1'b1 : 1'b0);
      check_val("r_id", axi.r_id, id);
      check_val("r_resp", axi.r_resp, 2'b00);
      check_busy_readies();
      if (axi.r_ready) hs++;
      else stall_left--;
      tick();
      cyc++;
    end
    axi.r_ready = 1'b1;
    check_val("r_handshakes", hs, 4);
    #1;
    check_val("r_valid_done", axi.r_valid, 1'b0);
  endtask

  // Write burst of nbeats beats; w_last on the final one when last_final.
  task automatic do_write(input logic [2:0] id, input logic [55:0] addr, input logic [511:0] line,
                          input int nbeats, input logic last_final);
    logic err;
    err = !(nbeats == 4 && last_final);
    axi.aw_valid = 1'b1; axi.aw_id = id; axi.aw_addr = addr;
    #1;
    check_val("wr_aw_ready", axi.aw_ready, 1'b1);
    check_val("wr_ar_ready_off", axi.ar_ready, 1'b0);
    tick();
    if (!hold) axi.aw_valid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      axi.w_valid = 1'b1;
      axi.w_data  = line[k*128 +: 128];
      axi.w_last  = (k == nbeats - 1) ? last_final : 1'b0;
      #1;
      check_val("w_ready", axi.w_ready, 1'b1);
      check_val("wr_data_req_low", l2_req_valid, 1'b0);
      check_busy_readies();
      tick();
    end
    axi.w_valid = 1'b0; axi.w_last = 1'b0; axi.w_data = '0;
    if (!err) begin
      #1;
      check_val("wr_req_valid", l2_req_valid, 1'b1);
      check_val("wr_req_wr", l2_req_wr, 1'b1);
      check_val("wr_req_addr", l2_req_addr, addr[55:6]);
      check_val("wr_req_data", l2_req_data, line);
      tick();
    end
    #1;
    check_val("b_valid", axi.b_valid, 1'b1);
    check_val("b_id", axi.b_id, id);
    check_val("b_resp", axi.b_resp, err ? 2'b10 : 2'b00);
    check_val("b_req_low", l2_req_valid, 1'b0);
    check_busy_readies();
    tick();
    #1;
    check_val("b_valid_done", axi.b_valid, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    #1;
    check_val("rst_r_valid", axi.r_valid, 1'b0);
    check_val("rst_b_valid", axi.b_valid, 1'b0);
    check_val("rst_w_ready", axi.w_ready, 1'b0);
    check_val("rst_req_valid", l2_req_valid, 1'b0);
    check_val("rst_ar_ready", axi.ar_ready, 1'b0);
    check_val("rst_aw_ready", axi.aw_ready, 1'b0);
    rst = 1'b0;
  endtask

  logic [511:0] line_r0, line_r1, line_r2, line_w0, line_w1;

  initial begin
    line_r0 = {128'hD3D3_0000_0000_0000_0000_0000_0000_0003, 128'hD2D2_0000_0000_0000_0000_0000_0000_0002,
               128'hD1D1_0000_0000_0000_0000_0000_0000_0001, 128'hD0D0_0000_0000_0000_0000_0000_0000_0000};
    line_r1 = {128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'hCAFE_BABE_DEAD_BEEF_0000_1111_2222_3333, 128'h5A5A_A5A5_5A5A_A5A5_5A5A_A5A5_5A5A_A5A5};
    line_r2 = {128'h0000_0000_0000_0000_0000_0000_0000_00FF, 128'hFF00_0000_0000_0000_0000_0000_0000_0000,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0000_0000_0000_0001_0000_0000_0000_0000};
    line_w0 = {128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD, 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC,
               128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA};
    line_w1 = {128'h4444_0000_0000_0000_0000_0000_0000_0004, 128'h3333_0000_0000_0000_0000_0000_0000_0003,
               128'h2222_0000_0000_0000_0000_0000_0000_0002, 128'h1111_0000_0000_0000_0000_0000_0000_0001};
    hold = 1'b0;
    rst = 1'b1;
    axi.ar_valid = 1'b0; axi.ar_id = '0; axi.ar_addr = '0;
    axi.aw_valid = 1'b0; axi.aw_id = '0; axi.aw_addr = '0;
    axi.w_valid = 1'b0; axi.w_data = '0; axi.w_last = 1'b0;
    axi.r_ready = 1'b1; axi.b_ready = 1'b1;
    l2_req_ready = 1'b1; l2_rsp_valid = 1'b0; l2_rsp_data = '0;
    tick();
    pulse_reset();
    check_val("rst_r_data", axi.r_data, '0);
    check_val("rst_r_last", axi.r_last, 1'b0);
    check_val("rst_r_id", axi.r_id, '0);
    check_val("rst_b_resp", axi.b_resp, 2'b00);
    check_val("rst_req_addr", l2_req_addr, '0);
    check_val("rst_req_data", l2_req_data, '0);

    // Read without stall, documented example address.
    do_read(3'd5, 56'h0000_0080_0010_40, line_r0, -1, -1);
    check_val("rd_addr_example", 50'h200_0041, 56'h0000_0080_0010_40 >> 6);
    // Read with r_ready low for 3 cycles on beat 1.
    do_read(3'd1, 56'h00_0000_1234_5680, line_r1, 1, -1);
    // Good write burst.
    do_write(3'd2, 56'h00_0000_4000_0000, line_w0, 4, 1'b1);
    // Early w_last on beat 1, then a normal read.
    do_write(3'd3, 56'h00_0000_4000_0040, line_w1, 2, 1'b1);
    do_read(3'd4, 56'h00_0000_0000_0100, line_r2, -1, -1);
    // Four beats with no w_last.
    do_write(3'd6, 56'h00_0000_7700_0000, line_w1, 4, 1'b0);

    // Both valids held: read, write, read.
    pulse_reset();
    hold = 1'b1;
    axi.aw_valid = 1'b1; axi.aw_id = 3'd7; axi.aw_addr = 56'h00_0000_5000_0000;
    do_read(3'd0, 56'h00_0000_6000_0000, line_r1, -1, -1);
    do_write(3'd7, 56'h00_0000_5000_0000, line_w0, 4, 1'b1);
    do_read(3'd0, 56'h00_0000_6000_0000, line_r2, -1, -1);
    check_val("alt_aw_ready_next", axi.aw_ready, 1'b1);
    check_val("alt_ar_ready_next", axi.ar_ready, 1'b0);
    hold = 1'b0;
    axi.ar_valid = 1'b0; axi.aw_valid = 1'b0;
    tick();

    // Reset during beat 2, then a fresh read.
    do_read(3'd2, 56'h00_0000_0000_2000, line_r0, -1, 2);
    do_read(3'd3, 56'h00_0000_0000_3040, line_r1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
